jt1943_romrq_arb: RTL and testbench

Arbiter that shares one 32-bit SDRAM read port between up to eight ROM request caches (graphics, sound, CPU ROM slots). Each cache raises a request with a word-aligned address on a miss. The arbiter picks one slot, runs the SDRAM read handshake, and returns the 32-bit word with a write strobe aligned to the cache's clock enable. It sits between the per-slot ROM caches and the SDRAM controller's read channel.

---
 rtl/jt1943_arb_pkg.sv | 19 +
 rtl/jt1943_arb_pick.sv | 52 +++++
 rtl/jt1943_romrq_arb.sv | 134 +++++++++++++
 tb/tb_jt1943_romrq_arb.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jt1943_arb_pkg.sv
// Shared types for the ROM-request arbiter: FSM state encoding, slot limit,
// and the winner-index width helper.
package jt1943_arb_pkg;

  localparam int MAX_SLOTS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DATA,
    ST_WE
  } arb_state_e;

  // A single requester still needs a 1-bit index.
  function automatic int idx_width(input int slots);
    return (slots > 1) ? $clog2(slots) : 1;
  endfunction

endpackage

// File: rtl/jt1943_arb_pick.sv
// Combinational winner picker. With JT1943_ARB_RR_EN the search starts at ptr_i
// and wraps; otherwise the lowest requesting index wins.
module jt1943_arb_pick
  import jt1943_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int WW    = idx_width(SLOTS)
) (
  input  logic [SLOTS-1:0] req_i,
`ifdef JT1943_ARB_RR_EN
  input  logic [WW-1:0]    ptr_i,
`endif
  output logic             valid_o,
  output logic [WW-1:0]    idx_o
);

`ifdef JT1943_ARB_RR_EN
  logic [WW:0] cand;
  logic        found;

  // Walk offsets 0..SLOTS-1 from the pointer; the first requesting slot wins.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int i = 0; i < SLOTS; i++) begin
      cand = {1'b0, ptr_i} + (WW+1)'(i);
      if (cand >= (WW+1)'(SLOTS)) cand = cand - (WW+1)'(SLOTS);
      for (int j = 0; j < SLOTS; j++) begin
        if (!found && req_i[j] && (cand == (WW+1)'(j))) begin
          found = 1'b1;
          idx_o = WW'(j);
        end
      end
    end
    valid_o = found;
  end
`else
  // NOTE: every output gets a default first so no path through the loop infers a latch.
  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        valid_o = 1'b1;
        idx_o   = WW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/jt1943_romrq_arb.sv
// Shares one SDRAM read port among SLOTS ROM caches (IDLE/REQ/DATA/WE FSM).
// Define JT1943_ARB_RR_EN for round-robin selection; default is fixed priority.
module jt1943_romrq_arb
  import jt1943_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW    = 22
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cen,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_we,
  output logic [31:0]         dout,
  output logic                busy,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic                sdram_rdy,
  input  logic [31:0]         sdram_din
);

  localparam int WW = idx_width(SLOTS);

  arb_state_e       state_q;
  logic [WW-1:0]    win_q;
  logic [SLOTS-1:0] slot_we_q;
  logic [31:0]      dout_q;
  logic             busy_q;
  logic             sdram_req_q;
  logic [AW-1:0]    sdram_addr_q;

  logic             pick_valid;
  logic [WW-1:0]    pick_idx;
  logic [AW-1:0]    pick_addr;
  logic [SLOTS-1:0] win_oh;

`ifdef JT1943_ARB_RR_EN
  logic [WW-1:0]    rr_ptr_q;
  logic [WW-1:0]    rr_ptr_d;

  // Next search starts just after the slot being granted.
  always_comb begin
    rr_ptr_d = (pick_idx == WW'(SLOTS - 1)) ? '0 : pick_idx + 1'b1;
  end
`endif

  jt1943_arb_pick #(
    .SLOTS (SLOTS),
    .WW    (WW)
  ) u_pick (
    .req_i   (slot_req),
`ifdef JT1943_ARB_RR_EN
    .ptr_i   (rr_ptr_q),
`endif
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_addr = '0;
    win_oh    = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (pick_idx == WW'(i)) pick_addr = slot_addr[i*AW +: AW];
      win_oh[i] = (win_q == WW'(i));
    end
  end

  // NOTE: all state below updates with <= so every branch sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      win_q        <= '0;
      slot_we_q    <= '0;
      dout_q       <= '0;
      busy_q       <= 1'b0;
      sdram_req_q  <= 1'b0;
      sdram_addr_q <= '0;
`ifdef JT1943_ARB_RR_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            win_q        <= pick_idx;
            sdram_addr_q <= pick_addr;
            sdram_req_q  <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_REQ;
`ifdef JT1943_ARB_RR_EN
            rr_ptr_q     <= rr_ptr_d;
`endif
          end
        end
        ST_REQ: begin
          if (sdram_ack) begin
            sdram_req_q <= 1'b0;
            if (sdram_rdy) begin
              dout_q    <= sdram_din;
              slot_we_q <= win_oh;
              state_q   <= ST_WE;
            end else begin
              state_q   <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (sdram_rdy) begin
            dout_q    <= sdram_din;
            slot_we_q <= win_oh;
            state_q   <= ST_WE;
          end
        end
        ST_WE: begin
          if (cen) begin
            slot_we_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign slot_we    = slot_we_q;
  assign dout       = dout_q;
  assign busy       = busy_q;
  assign sdram_req  = sdram_req_q;
  assign sdram_addr = sdram_addr_q;

endmodule

// File: tb/tb_jt1943_romrq_arb.sv
// Directed bench for jt1943_romrq_arb: a per-cycle vector table plus hand-written
// sequences for contention, cen throttling, request withdrawal and mid-DATA reset.
module tb_jt1943_romrq_arb;

  localparam int SLOTS = 4;
  localparam int AW    = 22;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cen = 1'b1;
  logic [SLOTS-1:0]    slot_req = '0;
  logic [SLOTS*AW-1:0] slot_addr = '0;
  logic [SLOTS-1:0]    slot_we;
  logic [31:0]         dout;
  logic                busy;
  logic                sdram_req;
  logic [AW-1:0]       sdram_addr;
  logic                sdram_ack = 1'b0;
  logic                sdram_rdy = 1'b0;
  logic [31:0]         sdram_din = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  jt1943_romrq_arb #(.SLOTS(SLOTS), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cen        (cen),
    .slot_req   (slot_req),
    .slot_addr  (slot_addr),
    .slot_we    (slot_we),
    .dout       (dout),
    .busy       (busy),
    .sdram_req  (sdram_req),
    .sdram_addr (sdram_addr),
    .sdram_ack  (sdram_ack),
    .sdram_rdy  (sdram_rdy),
    .sdram_din  (sdram_din)
  );

  typedef struct {
    logic [3:0]    req;
    logic          ack;
    logic          rdy;
    logic          cen;
    logic [31:0]   din;
    logic [3:0]    exp_we;
    logic          exp_sreq;
    logic          exp_busy;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_dout;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [AW-1:0] addr_of(input int s);
    case (s)
      0:       return 22'h00010;
      1:       return 22'h00111;
      2:       return 22'h01234;
      default: return 22'h3FFFFF;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // One full clock: the active edge, then back to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_sreq(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (sdram_req) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic add(input logic [3:0] req, input logic ack, input logic rdy, input logic c,
                     input logic [31:0] din, input logic [3:0] we, input logic sreq,
                     input logic bsy, input logic [AW-1:0] eaddr, input logic [31:0] edout);
    vec_t v;
    v.req = req;  v.ack = ack;  v.rdy = rdy;  v.cen = c;  v.din = din;
    v.exp_we = we;  v.exp_sreq = sreq;  v.exp_busy = bsy;
    v.exp_addr = eaddr;  v.exp_dout = edout;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    bit ok;
    int exp_order[4];

    slot_addr = {addr_of(3), addr_of(2), addr_of(1), addr_of(0)};

    // Reset state
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_sreq", 64'(sdram_req), 64'(0));
    check("rst_we",   64'(slot_we), 64'(0));
    check("rst_dout", 64'(dout), 64'(0));
    check("rst_addr", 64'(sdram_addr), 64'(0));
    rst_n = 1'b1;

    // Each row: drive inputs, one clock edge, then expected outputs.
    // Slot 2 single request: ack on the 2nd REQ cycle, rdy 3 cycles later.
    add(4'b0100, 0, 0, 1, 32'h0,        4'b0000, 1, 1, 22'h01234, 32'h0);
    add(4'b0100, 0, 0, 1, 32'h0,        4'b0000, 1, 1, 22'h01234, 32'h0);
    add(4'b0100, 1, 0, 1, 32'h0,        4'b0000, 0, 1, 22'h0,     32'h0);
    add(4'b0100, 0, 0, 1, 32'h0,        4'b0000, 0, 1, 22'h0,     32'h0);
    add(4'b0100, 0, 0, 1, 32'h0,        4'b0000, 0, 1, 22'h0,     32'h0);
    add(4'b0100, 0, 1, 1, 32'hDEADBEEF, 4'b0100, 0, 1, 22'h0,     32'hDEADBEEF);
    add(4'b0000, 0, 0, 1, 32'h0,        4'b0000, 0, 0, 22'h0,     32'h0);
    // Stray rdy and ack in IDLE are ignored.
    add(4'b0000, 0, 1, 1, 32'h11111111, 4'b0000, 0, 0, 22'h0,     32'h0);
    add(4'b0000, 1, 0, 1, 32'h0,        4'b0000, 0, 0, 22'h0,     32'h0);
    // Slot 3 at the top address, ack and rdy together: DATA is skipped.
    add(4'b1000, 0, 0, 1, 32'h0,        4'b0000, 1, 1, 22'h3FFFFF, 32'h0);
    add(4'b1000, 1, 1, 1, 32'hCAFEF00D, 4'b1000, 0, 1, 22'h0,     32'hCAFEF00D);
    add(4'b0000, 0, 0, 1, 32'h0,        4'b0000, 0, 0, 22'h0,     32'h0);

    foreach (vecs[i]) begin
      slot_req  = vecs[i].req;
      sdram_ack = vecs[i].ack;
      sdram_rdy = vecs[i].rdy;
      cen       = vecs[i].cen;
      sdram_din = vecs[i].din;
      tick();
      check($sformatf("vec%0d_we", i),   64'(slot_we),   64'(vecs[i].exp_we));
      check($sformatf("vec%0d_sreq", i), 64'(sdram_req), 64'(vecs[i].exp_sreq));
      check($sformatf("vec%0d_busy", i), 64'(busy),      64'(vecs[i].exp_busy));
      if (vecs[i].exp_sreq)
        check($sformatf("vec%0d_addr", i), 64'(sdram_addr), 64'(vecs[i].exp_addr));
      if (vecs[i].exp_we != 4'b0000)
        check($sformatf("vec%0d_dout", i), 64'(dout), 64'(vecs[i].exp_dout));
    end
    sdram_ack = 1'b0;
    sdram_rdy = 1'b0;

    // Contention: slots 0, 1 and 3 held high, zero-wait controller.
`ifdef JT1943_ARB_RR_EN
    exp_order = '{0, 1, 3, 0};
`else
    exp_order = '{0, 0, 0, 0};
`endif
    do_reset();
    cen = 1'b1;
    slot_req = 4'b1011;
    for (int g = 0; g < 4; g++) begin
      wait_sreq(ok);
      check($sformatf("cont%0d_sreq", g), 64'(ok), 64'(1));
      check($sformatf("cont%0d_addr", g), 64'(sdram_addr), 64'(addr_of(exp_order[g])));
      sdram_ack = 1'b1;
      tick();
      sdram_ack = 1'b0;
      sdram_rdy = 1'b1;
      sdram_din = 32'hA000_0000 + 32'(g);
      tick();
      sdram_rdy = 1'b0;
      check($sformatf("cont%0d_we", g), 64'(slot_we), 64'(4'b0001 << exp_order[g]));
      check($sformatf("cont%0d_dout", g), 64'(dout), 64'(32'hA000_0000 + 32'(g)));
      tick();
      check($sformatf("cont%0d_we_clr", g), 64'(slot_we), 64'(0));
    end
    slot_req = 4'b0000;
    tick();

    // cen throttling: rdy lands on a cen=0 cycle, strobe holds until cen=1.
    do_reset();
    cen = 1'b0;
    slot_req = 4'b0010;
    tick();
    check("cen_sreq", 64'(sdram_req), 64'(1));
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_rdy = 1'b1;
    sdram_din = 32'h0BADCAFE;
    tick();
    sdram_rdy = 1'b0;
    check("cen_we_entry", 64'(slot_we), 64'(4'b0010));
    check("cen_dout", 64'(dout), 64'(32'h0BADCAFE));
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("cen_hold%0d_we", k), 64'(slot_we), 64'(4'b0010));
      check($sformatf("cen_hold%0d_sreq", k), 64'(sdram_req), 64'(0));
    end
    cen = 1'b1;
    tick();
    check("cen_we_clr", 64'(slot_we), 64'(0));
    check("cen_idle_busy", 64'(busy), 64'(0));
    check("cen_no_early_grant", 64'(sdram_req), 64'(0));
    cen = 1'b0;
    tick();
    check("cen_regrant", 64'(sdram_req), 64'(1));
    slot_req = 4'b0000;
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    sdram_rdy = 1'b1;
    tick();
    sdram_rdy = 1'b0;
    cen = 1'b1;
    tick();
    check("cen_final_busy", 64'(busy), 64'(0));

    // Slot 1 withdraws and changes address during DATA.
    slot_req = 4'b0010;
    tick();
    check("wd_addr_latch", 64'(sdram_addr), 64'(addr_of(1)));
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    slot_req = 4'b0000;
    slot_addr[1*AW +: AW] = 22'h0BBBB;
    tick();
    check("wd_busy", 64'(busy), 64'(1));
    check("wd_addr_hold", 64'(sdram_addr), 64'(addr_of(1)));
    sdram_rdy = 1'b1;
    sdram_din = 32'h5555AAAA;
    tick();
    sdram_rdy = 1'b0;
    check("wd_we", 64'(slot_we), 64'(4'b0010));
    check("wd_dout", 64'(dout), 64'(32'h5555AAAA));
    tick();
    check("wd_we_clr", 64'(slot_we), 64'(0));
    slot_addr[1*AW +: AW] = addr_of(1);

    // Reset while in DATA: outputs clear at once, a late rdy is ignored.
    slot_req = 4'b0001;
    tick();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    slot_req = 4'b0000;
    check("mid_busy_pre", 64'(busy), 64'(1));
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_sreq", 64'(sdram_req), 64'(0));
    check("mid_rst_we",   64'(slot_we), 64'(0));
    check("mid_rst_dout", 64'(dout), 64'(0));
    check("mid_rst_addr", 64'(sdram_addr), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sdram_rdy = 1'b1;
    sdram_din = 32'hFFFF0000;
    tick();
    sdram_rdy = 1'b0;
    check("late_rdy_we", 64'(slot_we), 64'(0));
    check("late_rdy_busy", 64'(busy), 64'(0));
    tick();
    check("late_rdy_we2", 64'(slot_we), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
